// File: rtl/mpmc_burst_addr_gen.sv
// mpmc_burst_addr_gen
// Burst command address generator for the multi-port memory controller.
// Takes one transfer request (base address, strip count, direction) and
// issues one line-aligned command address per DRAM burst, holding each
// command stable under back-pressure from the memory interface.
//
// Optional feature macro: MPMC_ADDR_WRAP_EN
//   defined   - address increments wrap inside the aligned 2^WRAP_LOG2-byte
//               region containing the base, keeping a transfer in one page
//   undefined - full-carry increment of the line field, WRAP_LOG2 unused
module mpmc_burst_addr_gen #(
   parameter int AW        = 32,
   parameter int LB        = 5,
   parameter int SW        = 6,
   parameter int WRAP_LOG2 = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [SW-1:0] req_nstrips,
   input  logic          req_we,
   input  logic          abort,
   output logic          cmd_valid,
   input  logic          cmd_rdy,
   output logic [AW-1:0] cmd_addr,
   output logic          cmd_we,
   output logic          cmd_last,
   output logic [SW-1:0] strip_cnt,
   output logic          done,
   output logic          aborted
);

   localparam int LW = AW - LB;

   // The wrap region must hold at least two lines and fit in the address.
   if (WRAP_LOG2 <= LB || WRAP_LOG2 > AW) begin : g_bad_wrap_log2
      $error("mpmc_burst_addr_gen: WRAP_LOG2 must be > LB and <= AW");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE,
      ABORT
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] nstr;
   logic [LW-1:0] line_cur;
   logic [LW-1:0] line_nxt;
   logic          accept_req;
   logic          accept_cmd;

   assign line_cur   = cmd_addr[AW-1:LB];
   assign cmd_last   = (strip_cnt == nstr);
   assign accept_req = req_valid && req_ready;
   assign accept_cmd = cmd_valid && cmd_rdy && !cmd_last;

`ifdef MPMC_ADDR_WRAP_EN
   // Only the line bits below the wrap boundary take part in the increment.
   localparam logic [LW-1:0] WRAP_MASK = {LW{1'b1}} >> (AW - WRAP_LOG2);

   // Next line address: carry is confined to the wrap region.
   always_comb begin
      line_nxt = (line_cur & ~WRAP_MASK) | ((line_cur + LW'(1)) & WRAP_MASK);
   end
`else
   // Next line address: plain modulo-2^(AW-LB) increment.
   always_comb begin
      line_nxt = line_cur + LW'(1);
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake/pulse outputs; abort beats a final accept.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      cmd_valid = 1'b0;
      done      = 1'b0;
      aborted   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cmd_valid = 1'b1;
            if (abort) begin
               state_nxt = ABORT;
            end else if (cmd_rdy && cmd_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ABORT: begin
            aborted   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Command datapath: latch the request, then step address and count on
   // every accepted non-final command; the final command leaves them held.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_addr  <= {AW{1'b1}};
         strip_cnt <= '0;
         nstr      <= '0;
         cmd_we    <= 1'b0;
      end else if (accept_req) begin
         cmd_addr  <= {req_addr[AW-1:LB], {LB{1'b0}}};
         strip_cnt <= '0;
         nstr      <= req_nstrips;
         cmd_we    <= req_we;
      end else if (accept_cmd) begin
         cmd_addr  <= {line_nxt, {LB{1'b0}}};
         strip_cnt <= strip_cnt + SW'(1);
      end
   end

endmodule
